// File: rtl/ntru_mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// ntru_mul_arb_pkg
//   Shared constants and types for the NTRU multiplier-sharing arbiter.
//   AW/BW/PW are the operand and product widths of the shared 12s x 9ns
//   truncating multiplier. LAT is its register depth.
//   TAG_W is sized for the largest supported requester count (4), so one
//   stage record type serves every legal NREQ. tag_width() gives the minimal
//   tag width for a given count, with a floor of one bit.
// -----------------------------------------------------------------------------
package ntru_mul_arb_pkg;

    localparam int AW       = 12;
    localparam int BW       = 9;
    localparam int PW       = 12;
    localparam int LAT      = 3;
    localparam int NREQ_MAX = 4;
    localparam int STAT_W   = 16;

    function automatic int tag_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    localparam int TAG_W = tag_width(NREQ_MAX);

    // One pipeline slot: valid flag, issuing requester, and product data.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PW-1:0]    data;
    } stage_t;

endpackage

// File: rtl/ntru_mul_pipe.sv
// -----------------------------------------------------------------------------
// ntru_mul_pipe
//   Three-stage, clock-enable gated truncating multiplier. A valid flag and a
//   requester tag travel alongside the data. Every stage holds while ce = 0.
//   Ports:
//     clk, reset (async, active-low)
//     ce                  - advance all stages
//     in_valid/in_tag     - issue qualifier and requester index
//     in_a (signed AW), in_b (unsigned BW)
//     out_stage           - output stage record (valid, tag, data)
//     busy                - any stage holds a valid issue
// -----------------------------------------------------------------------------
module ntru_mul_pipe
    import ntru_mul_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [AW-1:0]    in_a,
    input  logic [BW-1:0]    in_b,
    output stage_t           out_stage,
    output logic             busy
);

    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic [AW-1:0]    s1_a;
    logic [BW-1:0]    s1_b;
    stage_t           s2_q;
    stage_t           s3_q;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;

    // Only the low PW product bits are kept, and those depend only on the low
    // PW bits of each operand, so a PW x PW multiply of the sign-extended a
    // and zero-extended b gives the truncated signed product directly.
    assign a_ext = PW'($signed(s1_a));
    assign b_ext = PW'(s1_b);
    assign prod  = a_ext * b_ext;

    // Stage 1 captures the granted operands. Operands only load on a real
    // issue so idle cycles do not toggle the multiplier inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (ce) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            if (in_valid) begin
                s1_a <= in_a;
                s1_b <= in_b;
            end
        end
    end

    // Stage 2 registers the truncated product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_q <= '0;
        end else if (ce) begin
            s2_q.valid <= s1_valid;
            s2_q.tag   <= s1_tag;
            s2_q.data  <= prod;
        end
    end

    // Stage 3 is the output stage. Data only updates with a valid result, so
    // the shared result bus keeps its last value across bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3_q <= '0;
        end else if (ce) begin
            s3_q.valid <= s2_q.valid;
            s3_q.tag   <= s2_q.tag;
            if (s2_q.valid) begin
                s3_q.data <= s2_q.data;
            end
        end
    end

    assign out_stage = s3_q;
    assign busy      = s1_valid | s2_q.valid | s3_q.valid;

endmodule

// File: rtl/ntru_mul_share_arb.sv
// -----------------------------------------------------------------------------
// ntru_mul_share_arb
//   Round-robin arbiter that shares one pipelined truncating multiplier among
//   NREQ requesters (1..4). Each issue is tagged with its requester index and
//   the product is routed back to that requester. The whole pipeline stalls
//   while the output result is not accepted.
//   Ports:
//     clk, reset (async, active-low)
//     req_valid/req_ready   - per-requester operand handshake
//     req_a, req_b          - packed operands, requester i at [i*AW +: AW] etc.
//     rsp_valid/rsp_ready   - per-requester result handshake (valid one-hot)
//     rsp_data              - shared result bus
//     busy                  - any issue in flight
//   Optional (macro NTRU_MUL_ARB_STATS_EN):
//     stat_issue_cnt        - per-requester saturating 16-bit issue counters
//     stat_stall_cnt        - saturating count of stall cycles
// -----------------------------------------------------------------------------
module ntru_mul_share_arb
    import ntru_mul_arb_pkg::*;
#(
    parameter int NREQ = 2
)
(
    input  logic [0:0]         clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_a,
    input  logic [NREQ*BW-1:0] req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [PW-1:0]      rsp_data,
    output logic               busy
`ifdef NTRU_MUL_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_issue_cnt,
    output logic [STAT_W-1:0]      stat_stall_cnt
`endif
);

    logic [TAG_W-1:0] ptr_q;
    stage_t           out_stage;
    logic             out_ready;
    logic             stall;
    logic             ce;
    logic [NREQ-1:0]  grant;
    logic [TAG_W-1:0] grant_idx;
    logic             grant_any;
    logic             transfer;
    logic [AW-1:0]    sel_a;
    logic [BW-1:0]    sel_b;

    // Pick the ready bit of whichever requester owns the output result.
    always_comb begin
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (out_stage.tag == TAG_W'(i)) begin
                out_ready = rsp_ready[i];
            end
        end
    end

    assign stall = out_stage.valid && !out_ready;
    assign ce    = !stall;

    // Round-robin search: first look at indices at or above the pointer, then
    // wrap around to the ones below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i] && (TAG_W'(i) >= ptr_q)) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = TAG_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i] && (TAG_W'(i) < ptr_q)) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = TAG_W'(i);
            end
        end
    end

    // Ready is withheld while stalled and while reset is asserted, so nothing
    // appears accepted that the pipeline would not capture.
    assign req_ready = grant & {NREQ{ce && reset}};
    assign transfer  = grant_any && ce && reset;

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*AW +: AW];
                sel_b = req_b[i*BW +: BW];
            end
        end
    end

    // The pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (transfer) begin
            ptr_q <= (grant_idx == TAG_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    ntru_mul_pipe u_pipe (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (transfer),
        .in_tag    (grant_idx),
        .in_a      (sel_a),
        .in_b      (sel_b),
        .out_stage (out_stage),
        .busy      (busy)
    );

    // Route the output valid to the owning requester only.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = out_stage.valid && (out_stage.tag == TAG_W'(i));
        end
    end

    assign rsp_data = out_stage.data;

`ifdef NTRU_MUL_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] issue_cnt_q;
    logic [STAT_W-1:0]           stall_cnt_q;

    // Saturating event counters: issues per requester and stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (transfer && grant[i] && (issue_cnt_q[i] != {STAT_W{1'b1}})) begin
                    issue_cnt_q[i] <= issue_cnt_q[i] + 1'b1;
                end
            end
            if (stall && (stall_cnt_q != {STAT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign stat_issue_cnt = issue_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ntru_mul_share_arb.sv
// -----------------------------------------------------------------------------
// tb_ntru_mul_share_arb
//   Self-checking bench for ntru_mul_share_arb (NREQ = 2). A queue-based
//   model of issued operations is compared against the DUT on every falling
//   edge, and directed scenarios pin exact latencies, grant orders and
//   product values. Stats checks compile in with NTRU_MUL_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_ntru_mul_share_arb;
    import ntru_mul_arb_pkg::*;

    localparam int NREQ = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_a;
    logic [NREQ*BW-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [PW-1:0]      rsp_data;
    logic               busy;
`ifdef NTRU_MUL_ARB_STATS_EN
    logic [NREQ*16-1:0] stat_issue_cnt;
    logic [15:0]        stat_stall_cnt;
`endif

    ntru_mul_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef NTRU_MUL_ARB_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // Model state: one entry per issued operation, oldest first. age counts
    // non-stalled clock edges since the issue; a result is due at age 3.
    typedef struct {
        int            tag;
        logic [PW-1:0] data;
        int            age;
    } ent_t;

    ent_t          mq[$];
    int            mptr = 0;
    bit            mon_en = 1'b0;
    int            hs_tag[$];
    int            hs_cyc[$];
    int            acc_tag[$];
    logic [PW-1:0] acc_data[$];
    int            acc_cyc[$];
    int            m_issue[NREQ];
    int            m_stall = 0;

    function automatic logic [PW-1:0] model_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        longint sa;
        longint p;
        sa = longint'($signed(a));
        p  = sa * longint'(b);
        return p[PW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v,
                                 input logic [AW-1:0] a0, input logic [BW-1:0] b0,
                                 input logic [AW-1:0] a1, input logic [BW-1:0] b1,
                                 input logic [NREQ-1:0] rr);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        rsp_ready = rr;
    endtask

    task automatic clearModel();
        mq.delete();
        hs_tag.delete();
        hs_cyc.delete();
        acc_tag.delete();
        acc_data.delete();
        acc_cyc.delete();
        mptr    = 0;
        m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_issue[i] = 0;
    endtask

    task automatic resetDut();
        mon_en    = 1'b0;
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        clearModel();
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Compare process: derive the expected grant, response and busy from the
    // model, compare, then advance the model across the coming rising edge.
    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] exp_grant;
        logic [NREQ-1:0] exp_rv;
        logic [NREQ-1:0] exp_rr;
        bit              front_out;
        bit              stall_m;
        int              gi;
        if (mon_en) begin
            exp_grant = '0;
            gi = -1;
            for (int off = 0; off < NREQ; off++) begin
                if (gi < 0 && req_valid[(mptr + off) % NREQ]) gi = (mptr + off) % NREQ;
            end
            if (gi >= 0) exp_grant[gi] = 1'b1;
            front_out = (mq.size() > 0) && (mq[0].age >= 3);
            exp_rv = '0;
            if (front_out) exp_rv[mq[0].tag] = 1'b1;
            stall_m = front_out && !rsp_ready[mq[0].tag];
            exp_rr  = stall_m ? '0 : exp_grant;

            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            checkOutput("req_ready", 32'(req_ready), 32'(exp_rr));
            checkOutput("busy", 32'(busy), 32'(mq.size() > 0));
            if (front_out) checkOutput("rsp_data", 32'(rsp_data), 32'(mq[0].data));

            if (stall_m) begin
                m_stall++;
            end else begin
                if (front_out) begin
                    acc_tag.push_back(mq[0].tag);
                    acc_data.push_back(rsp_data);
                    acc_cyc.push_back(cyc);
                end
                foreach (mq[k]) mq[k].age++;
                if (front_out) void'(mq.pop_front());
                if (gi >= 0) begin
                    ent_t e;
                    e.tag  = gi;
                    e.data = model_prod(req_a[gi*AW +: AW], req_b[gi*BW +: BW]);
                    e.age  = 1;
                    mq.push_back(e);
                    hs_tag.push_back(gi);
                    hs_cyc.push_back(cyc);
                    m_issue[gi]++;
                    mptr = (gi + 1) % NREQ;
                end
            end
        end
    end

    initial begin : stimulus
        int  stall_start;
        bit  found;
        int  j;
        int  seen;

        // Reset values, with requests pending to show ready is held low.
        reset = 1'b0;
        applyStimulus(2'b11, 12'd1, 9'd1, 12'd2, 9'd2, 2'b11);
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'h0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);

        // Pin the model's arithmetic against hand-computed products.
        checkOutput("model_m5x3", 32'(model_prod(12'hFFB, 9'd3)), 32'hFF1);
        checkOutput("model_2047x511", 32'(model_prod(12'd2047, 9'd511)), 32'h601);
        checkOutput("model_m2048x511", 32'(model_prod(12'h800, 9'd511)), 32'h800);

        // Single issue from requester 0: result exactly three cycles later.
        resetDut();
        applyStimulus(2'b01, 12'hFFB, 9'd3, 12'd0, 9'd0, 2'b11);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t1_issues", 32'(hs_tag.size()), 32'd1);
        checkOutput("t1_results", 32'(acc_data.size()), 32'd1);
        if (acc_data.size() > 0 && hs_cyc.size() > 0) begin
            checkOutput("t1_data", 32'(acc_data[0]), 32'hFF1);
            checkOutput("t1_tag", 32'(acc_tag[0]), 32'd0);
            checkOutput("t1_latency", 32'(acc_cyc[0] - hs_cyc[0]), 32'd3);
        end

        // Both requesters continuously valid: alternating grants and results.
        resetDut();
        applyStimulus(2'b11, 12'd2047, 9'd511, 12'h800, 9'd511, 2'b11);
        repeat (10) @(posedge clk);
        #1;
        req_valid = '0;
        checkOutput("t2_issue_cnt", 32'(hs_tag.size() >= 4), 32'd1);
        checkOutput("t2_result_cnt", 32'(acc_data.size() >= 4), 32'd1);
        if (hs_tag.size() >= 4 && acc_data.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("t2_grant", 32'(hs_tag[k]), 32'(k % 2));
                checkOutput("t2_tag", 32'(acc_tag[k]), 32'(k % 2));
                checkOutput("t2_data", 32'(acc_data[k]), (k % 2 == 0) ? 32'h601 : 32'h800);
                if (k > 0) checkOutput("t2_back_to_back", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd1);
            end
        end
        repeat (6) @(posedge clk);
        #1;

        // Stall: requester 1 refuses its result for four cycles.
        resetDut();
        applyStimulus(2'b11, 12'd2047, 9'd511, 12'h800, 9'd511, 2'b01);
        found = 1'b0;
        stall_start = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (rsp_valid == 2'b10) begin
                found = 1'b1;
                stall_start = cyc;
                break;
            end
        end
        checkOutput("t3_req1_result_seen", 32'(found), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_stall_rsp_valid", 32'(rsp_valid), 32'h2);
            checkOutput("t3_stall_data", 32'(rsp_data), 32'h800);
            checkOutput("t3_stall_req_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        j = -1;
        for (int k = 0; k < acc_cyc.size(); k++) begin
            if (j < 0 && acc_cyc[k] == stall_start + 4) j = k;
        end
        checkOutput("t3_release_found", 32'(j >= 0 && j + 2 < acc_cyc.size()), 32'd1);
        if (j >= 0 && j + 2 < acc_cyc.size()) begin
            checkOutput("t3_release_tag", 32'(acc_tag[j]), 32'd1);
            checkOutput("t3_next1_tag", 32'(acc_tag[j+1]), 32'd0);
            checkOutput("t3_next1_data", 32'(acc_data[j+1]), 32'h601);
            checkOutput("t3_next1_cycle", 32'(acc_cyc[j+1] - acc_cyc[j]), 32'd1);
            checkOutput("t3_next2_tag", 32'(acc_tag[j+2]), 32'd1);
            checkOutput("t3_next2_data", 32'(acc_data[j+2]), 32'h800);
            checkOutput("t3_next2_cycle", 32'(acc_cyc[j+2] - acc_cyc[j]), 32'd2);
        end

        // Reset with three issues in flight: everything is discarded.
        resetDut();
        applyStimulus(2'b11, 12'd5, 9'd7, 12'd9, 9'd11, 2'b11);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_busy_before", 32'(busy), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        checkOutput("t4_rsp_valid_rst", 32'(rsp_valid), 32'h0);
        checkOutput("t4_busy_rst", 32'(busy), 32'h0);
        checkOutput("t4_req_ready_rst", 32'(req_ready), 32'h0);
        checkOutput("t4_rsp_data_rst", 32'(rsp_data), 32'h0);
        req_valid = '0;
        @(posedge clk); #1;
        clearModel();
        reset  = 1'b1;
        mon_en = 1'b1;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (rsp_valid != '0 || busy) seen++;
        end
        checkOutput("t4_no_stale", 32'(seen), 32'd0);

        // Only requester 1 valid with the pointer at 0: granted at once, and
        // the pointer wraps back to 0.
        resetDut();
        applyStimulus(2'b10, 12'd3, 9'd4, 12'd6, 9'd8, 2'b11);
        #1;
        checkOutput("t5_grant_req1", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b11;
        #1;
        checkOutput("t5_wrap_grant_req0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t5_results", 32'(acc_data.size()), 32'd2);
        if (acc_data.size() >= 2) begin
            checkOutput("t5_data_req1", 32'(acc_data[0]), 32'd48);
            checkOutput("t5_data_req0", 32'(acc_data[1]), 32'd12);
        end

`ifdef NTRU_MUL_ARB_STATS_EN
        // Statistics: five issues from requester 0, three from requester 1,
        // then two stalled cycles.
        resetDut();
        applyStimulus(2'b11, 12'd1, 9'd2, 12'd3, 9'd4, 2'b11);
        repeat (6) @(posedge clk);
        #1;
        req_valid = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        checkOutput("t6_stall_target", 32'(rsp_valid), 32'h2);
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t6_issue_cnt", 32'(stat_issue_cnt), {16'd3, 16'd5});
        checkOutput("t6_stall_cnt", 32'(stat_stall_cnt), 32'd2);
        checkOutput("t6_issue0_model", 32'(stat_issue_cnt[15:0]), 32'(m_issue[0]));
        checkOutput("t6_issue1_model", 32'(stat_issue_cnt[31:16]), 32'(m_issue[1]));
        checkOutput("t6_stall_model", 32'(stat_stall_cnt), 32'(m_stall));
`endif

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
